// File: rtl/pkt_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkt_write_arbiter: round-robin, word-granular share of one buffer write   |
// | port among NUM_PORT receive paths.                      Revision: 1.0     |
// +--------------------------------------------------------------------------+
module pkt_write_arbiter #(
  parameter int NUM_PORT = 4,
  parameter int PTR_W    = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [NUM_PORT-1:0]      iv_pkt_wr,
  input  logic [NUM_PORT*134-1:0]  iv_pkt,
  input  logic [NUM_PORT*16-1:0]   iv_pkt_bufadd,
  output logic [NUM_PORT-1:0]      ov_pkt_ack,
  output logic [133:0]             ov_pkt,
  output logic                     o_pkt_wr,
  output logic [15:0]              ov_pkt_bufadd,
  input  logic                     i_pkt_ack,
  output logic [PTR_W-1:0]         ov_grant_port,
  output logic                     o_timeout_pulse,
  output logic [1:0]               ov_arbiter_state
);

  localparam int c_word_w = 134;
  localparam int c_addr_w = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_ACK = 2'b01,
    ST_RELEASE  = 2'b10,
    ST_UNUSED   = 2'b11
  } state_t;

  state_t                r_state, w_state_d;
  logic [PTR_W-1:0]      r_ptr, w_ptr_d;
  logic [15:0]           r_timer, w_timer_d;
  logic [c_word_w-1:0]   w_pkt_d;
  logic [c_addr_w-1:0]   w_addr_d;
  logic                  w_wr_d;
  logic [PTR_W-1:0]      w_grant_d;
  logic [NUM_PORT-1:0]   w_ack_d;
  logic                  w_timeout_d;
  logic [PTR_W-1:0]      w_grant;
  logic [PTR_W-1:0]      w_idx;

  logic [c_word_w-1:0]   w_word [NUM_PORT];
  logic [c_addr_w-1:0]   w_addr [NUM_PORT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_unpack
      assign w_word[gi] = iv_pkt[gi*c_word_w +: c_word_w];
      assign w_addr[gi] = iv_pkt_bufadd[gi*c_addr_w +: c_addr_w];
    end
  endgenerate

  // Scan from farthest to nearest so the requester closest after r_ptr wins.
  always_comb begin
    w_grant = r_ptr;
    w_idx   = '0;
    for (int i = NUM_PORT; i >= 1; i--) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % NUM_PORT);
      if (iv_pkt_wr[w_idx]) begin
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_timer_d   = r_timer;
    w_pkt_d     = ov_pkt;
    w_addr_d    = ov_pkt_bufadd;
    w_wr_d      = o_pkt_wr;
    w_grant_d   = ov_grant_port;
    w_ack_d     = '0;
    w_timeout_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|iv_pkt_wr) begin
          w_pkt_d   = w_word[w_grant];
          w_addr_d  = w_addr[w_grant];
          w_wr_d    = 1'b1;
          w_grant_d = w_grant;
          w_ptr_d   = w_grant;
          w_timer_d = '0;
          w_state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // An ack on the final allowed cycle still counts as a successful write.
        if (i_pkt_ack) begin
          w_wr_d    = 1'b0;
          w_ack_d   = NUM_PORT'(1) << ov_grant_port;
          w_timer_d = '0;
          w_state_d = ST_RELEASE;
        end else if (r_timer == 16'(TIMEOUT - 1)) begin
          w_wr_d      = 1'b0;
          w_timeout_d = 1'b1;
          w_timer_d   = '0;
          w_state_d   = ST_RELEASE;
        end else begin
          w_timer_d = r_timer + 16'd1;
        end
      end
      ST_RELEASE: begin
        w_state_d = ST_IDLE;
      end
      default: begin
        w_wr_d    = 1'b0;
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_ptr           <= PTR_W'(NUM_PORT - 1);
      r_timer         <= '0;
      ov_pkt          <= '0;
      ov_pkt_bufadd   <= '0;
      o_pkt_wr        <= 1'b0;
      ov_grant_port   <= '0;
      ov_pkt_ack      <= '0;
      o_timeout_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_ptr           <= w_ptr_d;
      r_timer         <= w_timer_d;
      ov_pkt          <= w_pkt_d;
      ov_pkt_bufadd   <= w_addr_d;
      o_pkt_wr        <= w_wr_d;
      ov_grant_port   <= w_grant_d;
      ov_pkt_ack      <= w_ack_d;
      o_timeout_pulse <= w_timeout_d;
    end
  end

  assign ov_arbiter_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pkt_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pkt_write_arbiter: self-checking bench for pkt_write_arbiter.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pkt_write_arbiter;

  localparam int NP = 4;
  localparam int PW = 2;
  localparam int TO = 16;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [NP-1:0]     iv_pkt_wr;
  logic [NP*134-1:0] iv_pkt;
  logic [NP*16-1:0]  iv_pkt_bufadd;
  logic [NP-1:0]     ov_pkt_ack;
  logic [133:0]      ov_pkt;
  logic              o_pkt_wr;
  logic [15:0]       ov_pkt_bufadd;
  logic              i_pkt_ack;
  logic [PW-1:0]     ov_grant_port;
  logic              o_timeout_pulse;
  logic [1:0]        ov_arbiter_state;

  logic [133:0] word [NP];
  logic [15:0]  addr [NP];

  int tests = 0;
  int fails = 0;

  pkt_write_arbiter #(.NUM_PORT(NP), .PTR_W(PW), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .iv_pkt_wr(iv_pkt_wr), .iv_pkt(iv_pkt),
    .iv_pkt_bufadd(iv_pkt_bufadd), .ov_pkt_ack(ov_pkt_ack), .ov_pkt(ov_pkt),
    .o_pkt_wr(o_pkt_wr), .ov_pkt_bufadd(ov_pkt_bufadd), .i_pkt_ack(i_pkt_ack),
    .ov_grant_port(ov_grant_port), .o_timeout_pulse(o_timeout_pulse),
    .ov_arbiter_state(ov_arbiter_state)
  );

  always #5 clk_sys = ~clk_sys;

  always_comb begin
    iv_pkt        = '0;
    iv_pkt_bufadd = '0;
    for (int p = 0; p < NP; p++) begin
      iv_pkt[p*134 +: 134]      = word[p];
      iv_pkt_bufadd[p*16 +: 16] = addr[p];
    end
  end

  typedef struct {
    logic [3:0]  mask;
    int          delay;
    int          exp_grant;
    logic [15:0] exp_addr;
    int          exp_high;
    logic [3:0]  exp_ack;
    logic        exp_to;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic set_fixed_words();
    for (int p = 0; p < NP; p++) begin
      word[p] = {2'b01, {32{4'hA}}, 4'(p)};
      addr[p] = 16'h0020 + 16'(16 * p);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    iv_pkt_wr = '0;
    i_pkt_ack = 1'b0;
    tick();
    tick();
    check("reset_ctrl", {ov_pkt_ack, o_pkt_wr, ov_pkt_bufadd, ov_grant_port,
                         o_timeout_pulse, ov_arbiter_state}, '0);
    check("reset_pkt", ov_pkt, '0);
    reset_n = 1'b1;
  endtask

  task automatic wait_strobe(output int cyc);
    cyc = 0;
    while (!o_pkt_wr && cyc < 10) begin
      tick();
      cyc++;
    end
    check("strobe_seen", o_pkt_wr, 1'b1);
  endtask

  // Holds the strobe until the ack delay d expires (d >= TO means never ack).
  task automatic run_xfer(input int d, output int high, output logic [NP-1:0] ack_seen,
                          output logic to_seen, output logic stable);
    logic [133:0]  p0;
    logic [15:0]   a0;
    logic [PW-1:0] g0;
    p0 = ov_pkt; a0 = ov_pkt_bufadd; g0 = ov_grant_port;
    stable = 1'b1; high = 0; ack_seen = '0; to_seen = 1'b0;
    for (int w = 0; w < 40; w++) begin
      high++;
      i_pkt_ack = (w == d);
      tick();
      i_pkt_ack = 1'b0;
      if (!o_pkt_wr) begin
        ack_seen = ov_pkt_ack;
        to_seen  = o_timeout_pulse;
        break;
      end
      if (ov_pkt !== p0 || ov_pkt_bufadd !== a0 || ov_grant_port !== g0 ||
          ov_pkt_ack !== '0 || o_timeout_pulse !== 1'b0)
        stable = 1'b0;
    end
  endtask

  task automatic xfer_expect(input string tag, input int d, input int port);
    int            high;
    logic [NP-1:0] ack;
    logic          to;
    logic          stable;
    run_xfer(d, high, ack, to, stable);
    check({tag, "_stable"}, stable, 1'b1);
    if (d < TO) begin
      check({tag, "_high"}, high, d + 1);
      check({tag, "_ack"}, ack, 4'b0001 << port);
      check({tag, "_to"}, to, 1'b0);
    end else begin
      check({tag, "_high"}, high, TO);
      check({tag, "_ack"}, ack, 4'b0000);
      check({tag, "_to"}, to, 1'b1);
    end
  endtask

  task automatic grant_expect(input string tag, input int port);
    check({tag, "_grant"}, ov_grant_port, port);
    check({tag, "_pkt"}, ov_pkt, word[port]);
    check({tag, "_addr"}, ov_pkt_bufadd, addr[port]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    int            cyc, high, last, exp_p, d;
    logic [NP-1:0] mask, ack;
    logic          to, stable;

    vecs[0] = '{4'b0100,  1, 2, 16'h0040,  2, 4'b0100, 1'b0};
    vecs[1] = '{4'b0011,  0, 0, 16'h0020,  1, 4'b0001, 1'b0};
    vecs[2] = '{4'b1000,  3, 3, 16'h0050,  4, 4'b1000, 1'b0};
    vecs[3] = '{4'b1010,  5, 1, 16'h0030,  6, 4'b0010, 1'b0};
    vecs[4] = '{4'b1111, 20, 0, 16'h0020, 16, 4'b0000, 1'b1};
    vecs[5] = '{4'b0110, 15, 1, 16'h0030, 16, 4'b0010, 1'b0};
    vecs[6] = '{4'b1100, 16, 2, 16'h0040, 16, 4'b0000, 1'b1};

    set_fixed_words();
    reset_n = 1'b0; iv_pkt_wr = '0; i_pkt_ack = 1'b0;

    // Table: one transfer from reset per vector.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      iv_pkt_wr = vecs[v].mask;
      wait_strobe(cyc);
      check("vec_grant", ov_grant_port, vecs[v].exp_grant);
      check("vec_addr", ov_pkt_bufadd, vecs[v].exp_addr);
      check("vec_pkt", ov_pkt, word[vecs[v].exp_grant]);
      run_xfer(vecs[v].delay, high, ack, to, stable);
      check("vec_high", high, vecs[v].exp_high);
      check("vec_ack", ack, vecs[v].exp_ack);
      check("vec_to", to, vecs[v].exp_to);
      check("vec_stable", stable, 1'b1);
      iv_pkt_wr = '0;
      tick();
    end

    // Two simultaneous requests: port 0 then port 1, each acked once.
    do_reset();
    iv_pkt_wr = 4'b0011;
    wait_strobe(cyc);
    grant_expect("t2a", 0);
    xfer_expect("t2a", 1, 0);
    iv_pkt_wr = 4'b0010;
    wait_strobe(cyc);
    check("t2_latency", cyc, 2);
    grant_expect("t2b", 1);
    xfer_expect("t2b", 0, 1);
    iv_pkt_wr = 4'b0000;
    tick(); tick(); tick();
    check("t2_idle", {o_pkt_wr, ov_pkt_ack}, '0);

    // Fairness with all ports continuously requesting.
    do_reset();
    iv_pkt_wr = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      wait_strobe(cyc);
      check("t3_grant", ov_grant_port, k % NP);
      xfer_expect("t3", int'($urandom_range(0, 4)), k % NP);
    end
    iv_pkt_wr = '0;
    tick();

    // Timeout on port 1, port 3 served, port 1 re-granted.
    do_reset();
    iv_pkt_wr = 4'b1010;
    wait_strobe(cyc);
    grant_expect("t5a", 1);
    xfer_expect("t5a", 99, 1);
    wait_strobe(cyc);
    grant_expect("t5b", 3);
    xfer_expect("t5b", 2, 3);
    iv_pkt_wr = 4'b0010;
    wait_strobe(cyc);
    grant_expect("t5c", 1);
    xfer_expect("t5c", 0, 1);
    iv_pkt_wr = '0;
    tick();

    // Reset during WAIT_ACK aborts the write and restores port 0 priority.
    do_reset();
    iv_pkt_wr = 4'b1111;
    wait_strobe(cyc);
    xfer_expect("t6a", 0, 0);
    wait_strobe(cyc);
    grant_expect("t6b", 1);
    tick();
    reset_n = 1'b0;
    tick();
    check("t6_rst_ctrl", {ov_pkt_ack, o_pkt_wr, ov_grant_port, o_timeout_pulse, ov_arbiter_state}, '0);
    check("t6_rst_addr", ov_pkt_bufadd, 16'h0);
    reset_n = 1'b1;
    wait_strobe(cyc);
    grant_expect("t6c", 0);
    xfer_expect("t6c", 1, 0);
    iv_pkt_wr = '0;
    tick();

    // Randomized traffic against a transaction-level round-robin model.
    do_reset();
    last = NP - 1;
    for (int p = 0; p < NP; p++) begin
      word[p] = 134'({$urandom, $urandom, $urandom, $urandom, $urandom});
      addr[p] = 16'($urandom);
    end
    mask = 4'($urandom_range(1, 15));
    iv_pkt_wr = mask;
    for (int t = 0; t < 150; t++) begin
      wait_strobe(cyc);
      if (t > 0) check("rnd_latency", cyc, 2);
      exp_p = -1;
      for (int i = NP; i >= 1; i--)
        if (mask[(last + i) % NP]) exp_p = (last + i) % NP;
      grant_expect("rnd", exp_p);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 4)) : int'($urandom_range(0, 6));
      xfer_expect("rnd", d, exp_p);
      last = exp_p;
      if (d < TO) begin
        mask[exp_p] = 1'b0;
        word[exp_p] = 134'({$urandom, $urandom, $urandom, $urandom, $urandom});
        addr[exp_p] = 16'($urandom);
      end
      mask = mask | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if (mask == '0) mask = 4'b0001 << $urandom_range(0, NP - 1);
      iv_pkt_wr = mask;
      if ($urandom_range(0, 3) == 0) i_pkt_ack = 1'b1;
    end
    i_pkt_ack = 1'b0;
    iv_pkt_wr = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
